// File: rtl/alu_regfile.sv
// alu_regfile: integer register file with two combinational read ports and one
// synchronous write port, plus a stateless two-operand ALU.
//
// Ports
//   clk     - rising-edge clock for register writes
//   rst     - asynchronous active-low reset; clears every register
//   raddr1  - read port 1 address        rdata1 - read port 1 data (combinational)
//   raddr2  - read port 2 address        rdata2 - read port 2 data (combinational)
//   we      - write enable               waddr  - write address
//   wdata   - write data
//   src1    - ALU operand 1              src2   - ALU operand 2
//   aluop   - 00: zero, 01: add, 10: unsigned set-less-than, 11: zero
//   result  - ALU result (combinational)
module alu_regfile #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [1:0]      aluop,
  output logic [XLEN-1:0] result
);

  // One bit wider than the address so REGS == 32 is representable.
  localparam logic [5:0] RegsLim = 6'(REGS);

  localparam logic [1:0] OpAdd  = 2'b01;
  localparam logic [1:0] OpSltu = 2'b10;

  logic [XLEN-1:0] regs_q [REGS];
  logic [XLEN-1:0] regs_d [REGS];

  logic wr_en;
  logic rd1_valid;
  logic rd2_valid;

  // x0 is hardwired to zero, so it is never written; addresses past REGS are dropped.
  always_comb begin
    wr_en     = we && (waddr != 5'd0) && ({1'b0, waddr} < RegsLim);
    rd1_valid = (raddr1 != 5'd0) && ({1'b0, raddr1} < RegsLim);
    rd2_valid = (raddr2 != 5'd0) && ({1'b0, raddr2} < RegsLim);
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[waddr] = wdata;
    end
  end

  // Asynchronous clear also masks a write whose edge coincides with reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see only the registered state: no write-through bypass.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rd1_valid) begin
      rdata1 = regs_q[raddr1];
    end
    if (rd2_valid) begin
      rdata2 = regs_q[raddr2];
    end
  end

  always_comb begin
    result = '0;
    case (aluop)
      OpAdd:   result = src1 + src2;
      OpSltu:  result = {{(XLEN-1){1'b0}}, (src1 < src2)};
      default: result = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_regfile.sv
// Testbench for alu_regfile: directed checks followed by randomized traffic compared
// against a plain array/arithmetic reference model.
module tb_alu_regfile;

  localparam int XLEN = 64;
  localparam int REGS = 32;

  logic            clk;
  logic            rst;
  logic [4:0]      raddr1;
  logic [XLEN-1:0] rdata1;
  logic [4:0]      raddr2;
  logic [XLEN-1:0] rdata2;
  logic            we;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [1:0]      aluop;
  logic [XLEN-1:0] result;

  alu_regfile #(
    .XLEN(XLEN),
    .REGS(REGS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .raddr1(raddr1),
    .rdata1(rdata1),
    .raddr2(raddr2),
    .rdata2(rdata2),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .src1  (src1),
    .src2  (src2),
    .aluop (aluop),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference register contents.
  logic [XLEN-1:0] mregs [REGS];

  function automatic logic [XLEN-1:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return '0;
    return mregs[a];
  endfunction

  function automatic logic [XLEN-1:0] model_alu(input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b,
                                                input logic [1:0] op);
    logic [XLEN:0] sum;
    if (op == 2'd1) begin
      sum = {1'b0, a} + {1'b0, b};
      return sum[XLEN-1:0];
    end
    if (op == 2'd2) return (a < b) ? 64'd1 : 64'd0;
    return '0;
  endfunction

  // Rising-edge effect of a write on the reference model.
  task automatic model_edge();
    if (rst && we && waddr != 5'd0) mregs[waddr] = wdata;
  endtask

  task automatic model_reset();
    for (int i = 0; i < REGS; i++) mregs[i] = '0;
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_rd1"}, rdata1, model_read(raddr1));
    check({tag, "_rd2"}, rdata2, model_read(raddr2));
  endtask

  // Drive a write on the next rising edge, checking the pre-edge (old) value and
  // the post-edge value on both ports.
  task automatic do_write(input logic [4:0] a, input logic [XLEN-1:0] d, input string tag);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d; raddr1 = a; raddr2 = a;
    #1 check_reads({tag, "_pre"});
    @(posedge clk);
    model_edge();
    #1 check_reads({tag, "_post"});
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = 5'd1; raddr2 = 5'd31; src1 = 64'd3; src2 = 64'd4; aluop = 2'b01;

    // Reset state and ALU live during reset.
    #12;
    check("reset_rd1", rdata1, 64'd0);
    check("reset_rd2", rdata2, 64'd0);
    check("alu_in_reset", result, 64'd7);
    // Write attempted while held in reset must be blocked.
    we = 1'b1; waddr = 5'd4; wdata = 64'hAAAA;
    @(posedge clk);
    #1 raddr1 = 5'd4;
    #1 check("write_blocked_in_reset", rdata1, 64'd0);
    @(negedge clk);
    we = 1'b0;
    rst = 1'b1;

    // First edge after reset release accepts a write.
    do_write(5'd10, 64'hDEADBEEF_CAFEF00D, "x10");
    do_write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF, "x0");

    // ALU directed cases.
    aluop = 2'b01; src1 = 64'hFFFF_FFFF_FFFF_FFFF; src2 = 64'd2;
    #1 check("add_wrap", result, 64'd1);
    src1 = 64'h8000_0000; src2 = 64'hFFFF_FFFF_FFFF_FFFC;
    #1 check("add_neg", result, 64'h7FFF_FFFC);
    aluop = 2'b10; src1 = 64'd1; src2 = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 check("sltu_big", result, 64'd1);
    src1 = 64'd5; src2 = 64'd5;
    #1 check("sltu_eq", result, 64'd0);
    src1 = 64'd0; src2 = 64'd1;
    #1 check("sltu_lt", result, 64'd1);
    aluop = 2'b00; src1 = 64'h1234; src2 = 64'h5678;
    #1 check("op00_zero", result, 64'd0);
    aluop = 2'b11;
    #1 check("op11_zero", result, 64'd0);

    // we=0 leaves x3 alone over several edges.
    do_write(5'd3, 64'h55, "x3");
    @(negedge clk);
    we = 1'b0; waddr = 5'd3; wdata = 64'd7; raddr1 = 5'd3;
    repeat (3) @(posedge clk);
    #1 check("we0_x3", rdata1, 64'h55);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      raddr1 = 5'($urandom_range(0, 31));
      raddr2 = 5'($urandom_range(0, 31));
      we     = ($urandom_range(0, 3) != 0);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = {$urandom, $urandom};
      src1   = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 9));
      src2   = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 9));
      aluop  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) raddr1 = waddr;
      #1;
      check_reads("rand_pre");
      check("rand_alu", result, model_alu(src1, src2, aluop));
      @(posedge clk);
      model_edge();
      #1 check_reads("rand_post");
    end

    // Reset asserted mid-cycle clears x5 before the next edge.
    do_write(5'd5, 64'h1234, "x5");
    @(negedge clk);
    raddr1 = 5'd5; raddr2 = 5'd10;
    #2 rst = 1'b0;
    model_reset();
    #1 check("midreset_x5", rdata1, 64'd0);
    check("midreset_x10", rdata2, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_write(5'd7, 64'h77, "x7_after_reset");

    // Write whose edge coincides with reset assertion is lost.
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 64'h99; raddr1 = 5'd9;
    @(posedge clk);
    rst = 1'b0;
    model_reset();
    #1 check("coincident_reset_x9", rdata1, 64'd0);
    @(negedge clk);
    we = 1'b0; rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
